// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, frame sizes and the CRC-8 step
// used by both uart_tx and uart_rx.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned CRC_BITS  = 8;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   typedef enum logic [2:0] {
      TxIdle,
      TxSync,
      TxStart,
      TxData,
      TxParity,
      TxCrc,
      TxStop
   } tx_state_t;

   // One serial CRC-8 step, fed with bits in transmission order.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/uart_tx_control_path.sv
// UART transmitter sequencing: frame FSM, bit counter and handshake outputs.
module uart_tx_control_path
   import uart_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid_i,
   input  logic crc_en_i,
   input  logic trigger_i,
   output logic ready_o,
   output logic busy_o,
   output logic accept_o,
   output logic bit_advance_o,
   output logic last_bit_o,
   output logic crc_en_o,
   output logic is_tx_sync_o,
   output logic is_tx_start_o,
   output logic is_tx_data_o,
   output logic is_tx_parity_o,
   output logic is_tx_crc_o,
   output logic is_tx_stop_o
);

   tx_state_t   state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic        crc_en_q, crc_en_d;

   // Triggers in IDLE are ignored, so an acceptance-cycle trigger is never consumed.
   assign ready_o       = (state_q == TxIdle);
   assign busy_o        = ~ready_o;
   assign accept_o      = valid_i & ready_o;
   assign bit_advance_o = trigger_i & busy_o;
   assign crc_en_o      = crc_en_q;

   assign is_tx_sync_o   = (state_q == TxSync);
   assign is_tx_start_o  = (state_q == TxStart);
   assign is_tx_data_o   = (state_q == TxData);
   assign is_tx_parity_o = (state_q == TxParity);
   assign is_tx_crc_o    = (state_q == TxCrc);
   assign is_tx_stop_o   = (state_q == TxStop);

   // Last bit of the current DATA or CRC segment is on the line.
   assign last_bit_o = is_tx_crc_o ? (bit_cnt_q == 5'(CRC_BITS - 1))
                                   : (bit_cnt_q == 5'(DATA_BITS - 1));

   // State, bit counter and latched CRC enable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= TxIdle;
         bit_cnt_q <= '0;
         crc_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         crc_en_q  <= crc_en_d;
      end
   end

   // Next-state logic: one transition per trigger while busy.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      crc_en_d  = crc_en_q;
      unique case (state_q)
         TxIdle: begin
            if (accept_o) begin
               state_d   = TxSync;
               bit_cnt_d = '0;
               crc_en_d  = crc_en_i;
            end
         end
         TxSync: begin
            if (bit_advance_o) state_d = TxStart;
         end
         TxStart: begin
            if (bit_advance_o) begin
               state_d   = TxData;
               bit_cnt_d = '0;
            end
         end
         TxData: begin
            if (bit_advance_o) begin
               if (last_bit_o) state_d = TxParity;
               else            bit_cnt_d = bit_cnt_q + 5'd1;
            end
         end
         TxParity: begin
            if (bit_advance_o) begin
               if (crc_en_q) begin
                  state_d   = TxCrc;
                  bit_cnt_d = '0;
               end else begin
                  state_d = TxStop;
               end
            end
         end
         TxCrc: begin
            if (bit_advance_o) begin
               if (last_bit_o) state_d = TxStop;
               else            bit_cnt_d = bit_cnt_q + 5'd1;
            end
         end
         TxStop: begin
            if (bit_advance_o) state_d = TxIdle;
         end
         default: state_d = TxIdle;
      endcase
   end

endmodule

// File: rtl/uart_tx_data_path.sv
// UART transmitter datapath: shift register, parity, CRC LFSR and line register.
module uart_tx_data_path
   import uart_pkg::*;
#(
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] data_i,
   input  logic       accept_i,
   input  logic       bit_advance_i,
   input  logic       last_bit_i,
   input  logic       crc_en_i,
   input  logic       is_tx_sync_i,
   input  logic       is_tx_start_i,
   input  logic       is_tx_data_i,
   input  logic       is_tx_parity_i,
   input  logic       is_tx_crc_i,
   input  logic       is_tx_stop_i,
   output logic       tx_o,
   output logic       tx_int_o
);

   logic [7:0] shreg_q, shreg_d;
   logic [7:0] crc_q, crc_d;
   logic       par_q, par_d;
   logic       tx_q, tx_d;
   logic       tx_int_q, tx_int_d;

   assign tx_o     = tx_q;
   assign tx_int_o = tx_int_q;

   // Datapath registers; the line idles high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q  <= '0;
         crc_q    <= CRC8_INIT;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         tx_int_q <= 1'b0;
      end else begin
         shreg_q  <= shreg_d;
         crc_q    <= crc_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         tx_int_q <= tx_int_d;
      end
   end

   // Drive the next line bit on each trigger; the CRC register doubles as the
   // output shifter once all data bits have been folded in.
   always_comb begin
      shreg_d  = shreg_q;
      crc_d    = crc_q;
      par_d    = par_q;
      tx_d     = tx_q;
      tx_int_d = 1'b0;
      if (accept_i) begin
         shreg_d = data_i;
         crc_d   = CRC8_INIT;
         par_d   = 1'b0;
      end else if (bit_advance_i) begin
         if (is_tx_sync_i) begin
            tx_d = 1'b0;
         end else if (is_tx_start_i || (is_tx_data_i && !last_bit_i)) begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            crc_d   = crc8_step(crc_q, shreg_q[0]);
            par_d   = par_q ^ shreg_q[0];
         end else if (is_tx_data_i) begin
            tx_d = par_q ^ PARITY_ODD;
         end else if (is_tx_parity_i && crc_en_i) begin
            tx_d  = crc_q[0];
            crc_d = crc_q >> 1;
         end else if (is_tx_crc_i && !last_bit_i) begin
            tx_d  = crc_q[0];
            crc_d = crc_q >> 1;
         end else if (is_tx_parity_i || is_tx_crc_i) begin
            tx_d = 1'b1;
         end else if (is_tx_stop_i) begin
            tx_d     = 1'b1;
            tx_int_d = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter top: 8 data bits LSB first, parity, optional CRC-8, one stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic       crc_en_i,
   input  logic       trigger_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       tx_int_o
);

   logic accept, bit_advance, last_bit, crc_en_q;
   logic is_tx_sync, is_tx_start, is_tx_data, is_tx_parity, is_tx_crc, is_tx_stop;

   uart_tx_control_path u_control (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .valid_i        (valid_i),
      .crc_en_i       (crc_en_i),
      .trigger_i      (trigger_i),
      .ready_o        (ready_o),
      .busy_o         (busy_o),
      .accept_o       (accept),
      .bit_advance_o  (bit_advance),
      .last_bit_o     (last_bit),
      .crc_en_o       (crc_en_q),
      .is_tx_sync_o   (is_tx_sync),
      .is_tx_start_o  (is_tx_start),
      .is_tx_data_o   (is_tx_data),
      .is_tx_parity_o (is_tx_parity),
      .is_tx_crc_o    (is_tx_crc),
      .is_tx_stop_o   (is_tx_stop)
   );

   uart_tx_data_path #(
      .PARITY_ODD (PARITY_ODD)
   ) u_data (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .data_i         (data_i),
      .accept_i       (accept),
      .bit_advance_i  (bit_advance),
      .last_bit_i     (last_bit),
      .crc_en_i       (crc_en_q),
      .is_tx_sync_i   (is_tx_sync),
      .is_tx_start_i  (is_tx_start),
      .is_tx_data_i   (is_tx_data),
      .is_tx_parity_i (is_tx_parity),
      .is_tx_crc_i    (is_tx_crc),
      .is_tx_stop_i   (is_tx_stop),
      .tx_o           (tx_o),
      .tx_int_o       (tx_int_o)
   );

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: an even-parity and an odd-parity instance share stimulus.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       crc_en = 1'b0;
   logic       trigger = 1'b0;

   logic tx_e, ready_e, busy_e, int_e;
   logic tx_d, ready_d, busy_d, int_d;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx #(.PARITY_ODD(1'b0)) u_even (
      .clk_i     (clk),
      .rst_i     (rst),
      .data_i    (data),
      .valid_i   (valid),
      .ready_o   (ready_e),
      .crc_en_i  (crc_en),
      .trigger_i (trigger),
      .tx_o      (tx_e),
      .busy_o    (busy_e),
      .tx_int_o  (int_e)
   );

   uart_tx #(.PARITY_ODD(1'b1)) u_odd (
      .clk_i     (clk),
      .rst_i     (rst),
      .data_i    (data),
      .valid_i   (valid),
      .ready_o   (ready_d),
      .crc_en_i  (crc_en),
      .trigger_i (trigger),
      .tx_o      (tx_d),
      .busy_o    (busy_d),
      .tx_int_o  (int_d)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic trig();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
   endtask

   task automatic accept(input string tag, input logic [7:0] d, input logic c);
      data   = d;
      crc_en = c;
      valid  = 1'b1;
      step();
      valid  = 1'b0;
      check({tag, "_acc_ready"}, ready_e, 1'b0);
      check({tag, "_acc_busy"}, busy_e, 1'b1);
      check({tag, "_acc_tx"}, tx_e, 1'b1);
   endtask

   // seq is {stop, [crc7..crc0], parity, d7..d0, start}; bit i is on the line
   // after trigger i+1. The odd-parity instance differs only at the parity bit.
   task automatic run_frame(input string tag, input logic [18:0] seq, input int n);
      for (int i = 0; i < n; i++) begin
         trig();
         check($sformatf("%s_tx%0d", tag, i + 1), tx_e, seq[i]);
         check($sformatf("%s_odd_tx%0d", tag, i + 1), tx_d, (i == 9) ? ~seq[i] : seq[i]);
         check($sformatf("%s_int%0d", tag, i + 1), int_e, 1'b0);
         check($sformatf("%s_busy%0d", tag, i + 1), busy_e, 1'b1);
         step();
         check($sformatf("%s_hold%0d", tag, i + 1), tx_e, seq[i]);
      end
      valid = 1'b0;
      trig();
      check({tag, "_int_end"}, int_e, 1'b1);
      check({tag, "_odd_int_end"}, int_d, 1'b1);
      check({tag, "_ready_end"}, ready_e, 1'b1);
      check({tag, "_busy_end"}, busy_e, 1'b0);
      check({tag, "_tx_end"}, tx_e, 1'b1);
      step();
      check({tag, "_int_clr"}, int_e, 1'b0);
      check({tag, "_ready_after"}, ready_e, 1'b1);
   endtask

   initial begin
      // Reset for two cycles
      step();
      step();
      rst = 1'b0;
      check("rst_tx", tx_e, 1'b1);
      check("rst_ready", ready_e, 1'b1);
      check("rst_busy", busy_e, 1'b0);
      check("rst_int", int_e, 1'b0);

      // Trigger in IDLE does nothing
      trig();
      check("idle_trig_tx", tx_e, 1'b1);
      check("idle_trig_busy", busy_e, 1'b0);

      // 0x01 plain: start, 1,0..0, parity 1, stop
      accept("p01", 8'h01, 1'b0);
      run_frame("p01", 19'(11'b1_1_00000001_0), 11);

      // 0x01 with CRC 0x89
      accept("c01", 8'h01, 1'b1);
      run_frame("c01", 19'b1_10001001_1_00000001_0, 19);

      // 0xA5 with trigger in the acceptance cycle; even parity 0, odd 1
      data    = 8'hA5;
      crc_en  = 1'b0;
      valid   = 1'b1;
      trigger = 1'b1;
      step();
      valid   = 1'b0;
      trigger = 1'b0;
      check("a5_acc_busy", busy_e, 1'b1);
      check("a5_acc_tx", tx_e, 1'b1);
      step();
      check("a5_sync_tx", tx_e, 1'b1);
      run_frame("a5", 19'(11'b1_0_10100101_0), 11);

      // 0x00 with CRC: CRC all zero
      accept("c00", 8'h00, 1'b1);
      run_frame("c00", 19'b1_00000000_0_00000000_0, 19);

      // valid held high while busy, data/crc_en changed mid-frame
      data   = 8'hF0;
      crc_en = 1'b0;
      valid  = 1'b1;
      step();
      check("hold_acc_busy", busy_e, 1'b1);
      data   = 8'h0F;
      crc_en = 1'b1;
      run_frame("hold", 19'(11'b1_0_11110000_0), 11);
      step();
      check("hold_no_second", busy_e, 1'b0);

      // Reset during D3 of 0xF7 (D3 = 0)
      accept("rstmid", 8'hF7, 1'b0);
      for (int i = 0; i < 5; i++) trig();
      check("rstmid_d3", tx_e, 1'b0);
      rst = 1'b1;
      step();
      check("rstmid_tx", tx_e, 1'b1);
      check("rstmid_ready", ready_e, 1'b1);
      check("rstmid_busy", busy_e, 1'b0);
      check("rstmid_int", int_e, 1'b0);
      rst = 1'b0;
      trig();
      check("rstmid_idle_tx", tx_e, 1'b1);
      check("rstmid_idle_int", int_e, 1'b0);

      // 0x55 afterwards is clean
      accept("p55", 8'h55, 1'b0);
      run_frame("p55", 19'(11'b1_0_01010101_0), 11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
